// File: rtl/zjh_seq_ic_bundle.sv
// zjh_seq_ic_bundle: three independent 74HC-style sequential parts on one
// clock and one master reset -- a 161-style binary counter, a 194-style
// universal shift register and a 112-style JK flip-flop with async set/reset.
module zjh_seq_ic_bundle #(
  parameter int CNT_W = 4,
  parameter int SR_W  = 4
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             cnt_pe_n,
  input  logic             cnt_cep,
  input  logic             cnt_cet,
  input  logic [CNT_W-1:0] cnt_d,
  output logic [CNT_W-1:0] cnt_q,
  output logic             cnt_tc,
  input  logic [1:0]       sr_s,
  input  logic             sr_dsr,
  input  logic             sr_dsl,
  input  logic [SR_W-1:0]  sr_d,
  output logic [SR_W-1:0]  sr_q,
  input  logic             jk_sd_n,
  input  logic             jk_rd_n,
  input  logic             jk_j,
  input  logic             jk_k,
  output logic             jk_q,
  output logic             jk_qn
);

  logic jk_state;

  // Counter: a synchronous load takes priority over counting; counting needs both enables.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      cnt_q <= '0;
    end else if (!cnt_pe_n) begin
      cnt_q <= cnt_d;
    end else if (cnt_cep && cnt_cet) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Terminal count is a live decode of all-ones, gated by the T enable for cascading.
  always_comb begin
    cnt_tc = cnt_cet & (&cnt_q);
  end

  // Shift register: hold, shift toward Q(n-1), shift toward Q0, or parallel load.
  always_ff @(posedge Clk or posedge MR) begin
    if (MR) begin
      sr_q <= '0;
    end else begin
      case (sr_s)
        2'b01:   sr_q <= {sr_q[SR_W-2:0], sr_dsr};
        2'b10:   sr_q <= {sr_dsl, sr_q[SR_W-1:1]};
        2'b11:   sr_q <= sr_d;
        default: sr_q <= sr_q;
      endcase
    end
  end

  // JK storage: MR, then set, then clear act asynchronously; with both released J/K act on the edge.
  always_ff @(posedge Clk or posedge MR or negedge jk_sd_n or negedge jk_rd_n) begin
    if (MR) begin
      jk_state <= 1'b0;
    end else if (!jk_sd_n) begin
      jk_state <= 1'b1;
    end else if (!jk_rd_n) begin
      jk_state <= 1'b0;
    end else begin
      case ({jk_j, jk_k})
        2'b01:   jk_state <= 1'b0;
        2'b10:   jk_state <= 1'b1;
        2'b11:   jk_state <= ~jk_state;
        default: jk_state <= jk_state;
      endcase
    end
  end

  // JK outputs follow the async levels directly so a held clear is seen even after set releases first.
  always_comb begin
    jk_q  = jk_state;
    jk_qn = ~jk_state;
    if (MR) begin
      jk_q  = 1'b0;
      jk_qn = 1'b1;
    end else if (!jk_sd_n && !jk_rd_n) begin
      jk_q  = 1'b1;
      jk_qn = 1'b1;
    end else if (!jk_sd_n) begin
      jk_q  = 1'b1;
      jk_qn = 1'b0;
    end else if (!jk_rd_n) begin
      jk_q  = 1'b0;
      jk_qn = 1'b1;
    end
  end

endmodule

// File: tb/tb_zjh_seq_ic_bundle.sv
// tb_zjh_seq_ic_bundle: directed and randomized checks of the 74HC bundle
// against a small arithmetic reference model of the three parts.
module tb_zjh_seq_ic_bundle;

  logic       Clk = 1'b0;
  logic       MR;
  logic       cnt_pe_n, cnt_cep, cnt_cet;
  logic [3:0] cnt_d, cnt_q;
  logic       cnt_tc;
  logic [1:0] sr_s;
  logic       sr_dsr, sr_dsl;
  logic [3:0] sr_d, sr_q;
  logic       jk_sd_n, jk_rd_n, jk_j, jk_k, jk_q, jk_qn;

  int n_compared   = 0;
  int n_mismatched = 0;

  // reference model state
  int m_cnt;
  int m_sr;
  int m_jk;

  zjh_seq_ic_bundle #(.CNT_W(4), .SR_W(4)) dut (
    .Clk(Clk), .MR(MR),
    .cnt_pe_n(cnt_pe_n), .cnt_cep(cnt_cep), .cnt_cet(cnt_cet),
    .cnt_d(cnt_d), .cnt_q(cnt_q), .cnt_tc(cnt_tc),
    .sr_s(sr_s), .sr_dsr(sr_dsr), .sr_dsl(sr_dsl), .sr_d(sr_d), .sr_q(sr_q),
    .jk_sd_n(jk_sd_n), .jk_rd_n(jk_rd_n), .jk_j(jk_j), .jk_k(jk_k),
    .jk_q(jk_q), .jk_qn(jk_qn)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Asynchronous effects of MR and the JK set/clear, applied at the current input levels.
  task automatic modelAsync();
    if (MR) begin
      m_cnt = 0;
      m_sr  = 0;
      m_jk  = 0;
    end else if (!jk_sd_n) begin
      m_jk = 1;
    end else if (!jk_rd_n) begin
      m_jk = 0;
    end
  endtask

  // Effects of a rising clock edge, written as plain arithmetic on the model values.
  task automatic modelEdge();
    if (MR) return;
    if (!cnt_pe_n)                m_cnt = int'(cnt_d);
    else if (cnt_cep && cnt_cet)  m_cnt = (m_cnt + 1) % 16;
    case (sr_s)
      2'd1: m_sr = ((m_sr * 2) + int'(sr_dsr)) % 16;
      2'd2: m_sr = (m_sr / 2) + 8 * int'(sr_dsl);
      2'd3: m_sr = int'(sr_d);
      default: ;
    endcase
    if (jk_sd_n && jk_rd_n) begin
      if (jk_j && jk_k)  m_jk = 1 - m_jk;
      else if (jk_j)     m_jk = 1;
      else if (jk_k)     m_jk = 0;
    end
  endtask

  task automatic checkAll(input string tag);
    int exp_qn;
    exp_qn = (!MR && !jk_sd_n && !jk_rd_n) ? 1 : 1 - m_jk;
    checkOutput({tag, ".cnt_q"}, int'(cnt_q), m_cnt);
    checkOutput({tag, ".cnt_tc"}, int'(cnt_tc), (cnt_cet && m_cnt == 15) ? 1 : 0);
    checkOutput({tag, ".sr_q"}, int'(sr_q), m_sr);
    checkOutput({tag, ".jk_q"}, int'(jk_q), m_jk);
    checkOutput({tag, ".jk_qn"}, int'(jk_qn), exp_qn);
  endtask

  // Called just after a falling edge with inputs already driven: check the
  // asynchronous response before any clock edge, then clock once and recheck.
  task automatic applyStimulus(input string tag);
    #1;
    modelAsync();
    checkAll({tag, ".pre"});
    @(posedge Clk);
    modelEdge();
    #1;
    modelAsync();
    checkAll({tag, ".post"});
    @(negedge Clk);
  endtask

  task automatic idleInputs();
    MR = 1'b0; cnt_pe_n = 1'b1; cnt_cep = 1'b0; cnt_cet = 1'b0; cnt_d = 4'h0;
    sr_s = 2'b00; sr_dsr = 1'b0; sr_dsl = 1'b0; sr_d = 4'h0;
    jk_sd_n = 1'b1; jk_rd_n = 1'b1; jk_j = 1'b0; jk_k = 1'b0;
  endtask

  initial begin
    m_cnt = 0; m_sr = 0; m_jk = 0;
    idleInputs();
    MR = 1'b1;
    @(negedge Clk);
    applyStimulus("reset");
    MR = 1'b0;

    // count 0..15 and wrap back to 0
    cnt_cep = 1'b1; cnt_cet = 1'b1;
    for (int i = 0; i < 17; i++) applyStimulus("count");
    checkOutput("wrap_value", int'(cnt_q), 1);
    cnt_cep = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cnt_cep = 1'b1;
      applyStimulus("to15");
    end
    cnt_cep = 1'b0;
    #1 checkOutput("tc_at_15", int'(cnt_tc), 1);
    cnt_cet = 1'b0;
    #1 checkOutput("tc_at_15_cet0", int'(cnt_tc), 0);
    @(negedge Clk);

    // load 0xA with cep low, then hold with cep low and with cet low
    cnt_d = 4'hA; cnt_pe_n = 1'b0; cnt_cep = 1'b0; cnt_cet = 1'b1;
    applyStimulus("load");
    checkOutput("load_A", int'(cnt_q), 10);
    cnt_pe_n = 1'b1;
    applyStimulus("hold_cep0");
    cnt_cep = 1'b1; cnt_cet = 1'b0;
    applyStimulus("hold_cet0");
    checkOutput("hold_A", int'(cnt_q), 10);

    // shift register load, shift right, shift left, hold
    sr_d = 4'b0110; sr_s = 2'b11;
    applyStimulus("sr_load");
    checkOutput("sr_load_0110", int'(sr_q), 6);
    sr_s = 2'b01; sr_dsr = 1'b1;
    applyStimulus("sr_right");
    checkOutput("sr_right_1101", int'(sr_q), 13);
    sr_s = 2'b10; sr_dsl = 1'b0;
    applyStimulus("sr_left");
    checkOutput("sr_left_0110", int'(sr_q), 6);
    sr_s = 2'b00;
    for (int i = 0; i < 4; i++) applyStimulus("sr_hold");

    // JK synchronous behaviour
    jk_j = 1'b1; jk_k = 1'b0; applyStimulus("jk_set");
    checkOutput("jk_set_q", int'(jk_q), 1);
    jk_j = 1'b0; jk_k = 1'b0; applyStimulus("jk_hold");
    jk_j = 1'b1; jk_k = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("jk_toggle");
    checkOutput("jk_toggle_q", int'(jk_q), 0);
    jk_j = 1'b1; jk_k = 1'b0; applyStimulus("jk_set2");
    jk_j = 1'b0; jk_k = 1'b1; applyStimulus("jk_clear");

    // JK asynchronous controls
    jk_sd_n = 1'b0; jk_rd_n = 1'b0;
    #1 checkOutput("jk_both_q", int'(jk_q), 1);
    checkOutput("jk_both_qn", int'(jk_qn), 1);
    applyStimulus("jk_both");
    jk_rd_n = 1'b1; jk_j = 1'b0; jk_k = 1'b1;
    applyStimulus("jk_sd_only");
    jk_sd_n = 1'b1; jk_k = 1'b0;
    applyStimulus("jk_release");
    checkOutput("jk_release_q", int'(jk_q), 1);

    // master reset mid-count at 5
    cnt_d = 4'h5; cnt_pe_n = 1'b0; applyStimulus("preload5");
    cnt_pe_n = 1'b1;
    checkOutput("mid_count_5", int'(cnt_q), 5);
    MR = 1'b1;
    #1 checkOutput("mr_cnt", int'(cnt_q), 0);
    checkOutput("mr_jkqn", int'(jk_qn), 1);
    applyStimulus("mr");
    MR = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      MR       = ($urandom_range(0, 19) == 0);
      cnt_pe_n = ($urandom_range(0, 5) != 0);
      cnt_cep  = ($urandom_range(0, 3) != 0);
      cnt_cet  = ($urandom_range(0, 3) != 0);
      cnt_d    = 4'($urandom_range(0, 15));
      sr_s     = 2'($urandom_range(0, 3));
      sr_dsr   = 1'($urandom_range(0, 1));
      sr_dsl   = 1'($urandom_range(0, 1));
      sr_d     = 4'($urandom_range(0, 15));
      jk_sd_n  = ($urandom_range(0, 7) != 0);
      jk_rd_n  = ($urandom_range(0, 7) != 0);
      jk_j     = 1'($urandom_range(0, 1));
      jk_k     = 1'($urandom_range(0, 1));
      applyStimulus("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
